// File: rtl/garage_motor_driver.sv
// garage_motor_driver
//   Soft-start H-bridge gate driver for a garage door motor. Up/down
//   commands ramp a PWM duty cycle up to full scale, hold it, and ramp it
//   back down on stop or reversal. A dead interval with both gates off
//   separates every run from the next.
//
// Build option:
//   STALL_TIMEOUT_EN - when defined, a run counter trips a latched stall
//                      fault after RUN_LIMIT cycles in RUN; Clear releases it.
//                      When undefined, Fault is tied low and Clear is ignored.
//
// Ports:
//   CLK        in   rising-edge clock
//   RST        in   asynchronous active-high reset
//   Up_Motor   in   open-door command
//   Down_Motor in   close-door command
//   Clear      in   synchronous stall-fault clear
//   PWM_Up     out  registered high-side drive, up direction
//   PWM_Down   out  registered high-side drive, down direction
//   Duty       out  current duty value [PWM_BITS-1:0]
//   Busy       out  high whenever not IDLE
//   Fault      out  latched stall fault
module garage_motor_driver #(
  parameter int unsigned PWM_BITS    = 8,
  parameter int unsigned RAMP_DIV    = 16,
  parameter int unsigned RAMP_STEP   = 8,
  parameter int unsigned DEAD_CYCLES = 32,
  parameter int unsigned RUN_LIMIT   = 100000
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                Up_Motor,
  input  logic                Down_Motor,
  input  logic                Clear,
  output logic                PWM_Up,
  output logic                PWM_Down,
  output logic [PWM_BITS-1:0] Duty,
  output logic                Busy,
  output logic                Fault
);

  localparam int unsigned PRE_W  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int unsigned DEAD_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;

  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(RAMP_DIV - 1);
  localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_CYCLES - 1);
  localparam logic [PWM_BITS:0] DUTY_MAX  = {1'b0, {PWM_BITS{1'b1}}};
  localparam logic [PWM_BITS:0] STEP      = (PWM_BITS + 1)'(RAMP_STEP);

  typedef enum logic [2:0] {
    IDLE,
    RAMP_UP,
    RUN,
    RAMP_DOWN,
    DEAD,
    FAULT
  } state_e;

  typedef enum logic {
    DIR_UP,
    DIR_DN
  } dir_e;

  state_e              state_q, state_d;
  dir_e                dir_q, dir_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [DEAD_W-1:0]   dead_q, dead_d;
  logic                pwm_up_q, pwm_up_d;
  logic                pwm_dn_q, pwm_dn_d;

  logic                cmd_up, cmd_dn, cmd_dir;
  logic                pre_tick;
  logic [PRE_W-1:0]    pre_next;
  logic [PWM_BITS:0]   duty_sum, duty_diff;
  logic                up_sat, dn_zero;
  logic                drive, pwm_on;

  assign cmd_up  = Up_Motor & ~Down_Motor;
  assign cmd_dn  = Down_Motor & ~Up_Motor;
  assign cmd_dir = (dir_q == DIR_UP) ? cmd_up : cmd_dn;

  assign pre_tick = (pre_q == PRE_LAST);
  assign pre_next = pre_tick ? '0 : pre_q + 1'b1;

  // One extra bit so saturation is detected before the duty wraps.
  assign duty_sum  = {1'b0, duty_q} + STEP;
  assign duty_diff = {1'b0, duty_q} - STEP;
  assign up_sat    = (duty_sum >= DUTY_MAX);
  assign dn_zero   = ({1'b0, duty_q} <= STEP);

`ifdef STALL_TIMEOUT_EN
  localparam int unsigned RUN_W = (RUN_LIMIT > 1) ? $clog2(RUN_LIMIT) : 1;
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(RUN_LIMIT - 1);

  logic [RUN_W-1:0] run_q, run_d;
  logic             run_expired;

  assign run_expired = (run_q == RUN_LAST);
  assign run_d       = (state_q == RUN && state_d == RUN) ? run_q + 1'b1 : '0;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) run_q <= '0;
    else     run_q <= run_d;
  end

  assign Fault = (state_q == FAULT);
`else
  logic run_expired;
  logic unused_cfg;

  assign run_expired = 1'b0;
  assign unused_cfg  = Clear ^ (RUN_LIMIT == 0);
  assign Fault       = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    duty_d  = duty_q;
    pre_d   = '0;
    dead_d  = '0;

    case (state_q)
      IDLE: begin
        if (cmd_up || cmd_dn) begin
          dir_d   = cmd_dn ? DIR_DN : DIR_UP;
          state_d = RAMP_UP;
        end
      end

      RAMP_UP: begin
        // Command loss wins over a coincident tick so the ramp-down starts
        // from the duty that was actually being driven.
        if (!cmd_dir) begin
          state_d = RAMP_DOWN;
        end else begin
          pre_d = pre_next;
          if (pre_tick) begin
            if (up_sat) begin
              duty_d  = DUTY_MAX[PWM_BITS-1:0];
              state_d = RUN;
            end else begin
              duty_d = duty_sum[PWM_BITS-1:0];
            end
          end
        end
      end

      RUN: begin
        if (!cmd_dir) begin
          state_d = RAMP_DOWN;
        end else if (run_expired) begin
          duty_d  = '0;
          state_d = FAULT;
        end
      end

      RAMP_DOWN: begin
        if (cmd_dir) begin
          state_d = RAMP_UP;
        end else begin
          pre_d = pre_next;
          if (pre_tick) begin
            if (dn_zero) begin
              duty_d  = '0;
              state_d = DEAD;
            end else begin
              duty_d = duty_diff[PWM_BITS-1:0];
            end
          end
        end
      end

      DEAD: begin
        if (dead_q == DEAD_LAST) begin
          if (cmd_up || cmd_dn) begin
            dir_d   = cmd_dn ? DIR_DN : DIR_UP;
            state_d = RAMP_UP;
          end else begin
            state_d = IDLE;
          end
        end else begin
          dead_d = dead_q + 1'b1;
        end
      end

      FAULT: begin
        duty_d = '0;
`ifdef STALL_TIMEOUT_EN
        if (Clear) state_d = IDLE;
`else
        state_d = IDLE;
`endif
      end

      default: state_d = IDLE;
    endcase
  end

  // Gate drive is decided from the current registered state; a single dir
  // bit selects the side, so both gates can never be on together.
  assign drive    = (state_q == RAMP_UP) || (state_q == RUN) || (state_q == RAMP_DOWN);
  assign pwm_on   = (pwm_cnt_q < duty_q);
  assign pwm_up_d = drive && pwm_on && (dir_q == DIR_UP);
  assign pwm_dn_d = drive && pwm_on && (dir_q == DIR_DN);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      dir_q     <= DIR_UP;
      duty_q    <= '0;
      pwm_cnt_q <= '0;
      pre_q     <= '0;
      dead_q    <= '0;
      pwm_up_q  <= 1'b0;
      pwm_dn_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      duty_q    <= duty_d;
      pwm_cnt_q <= pwm_cnt_q + 1'b1;
      pre_q     <= pre_d;
      dead_q    <= dead_d;
      pwm_up_q  <= pwm_up_d;
      pwm_dn_q  <= pwm_dn_d;
    end
  end

  assign PWM_Up   = pwm_up_q;
  assign PWM_Down = pwm_dn_q;
  assign Duty     = duty_q;
  assign Busy     = (state_q != IDLE);

endmodule

// File: tb/tb_garage_motor_driver.sv
// tb_garage_motor_driver
//   Directed bench for garage_motor_driver with default ramp/dead timing and
//   RUN_LIMIT=1000. Inputs change 1 ns after a rising edge and outputs are
//   read at that point or on the falling edge.
module tb_garage_motor_driver;

  logic       CLK = 1'b0;
  logic       RST;
  logic       Up_Motor;
  logic       Down_Motor;
  logic       Clear;
  logic       PWM_Up;
  logic       PWM_Down;
  logic [7:0] Duty;
  logic       Busy;
  logic       Fault;

  int n_checks = 0;
  int n_errors = 0;
  int up_hi    = 0;
  int dn_hi    = 0;
  int overlap  = 0;

  garage_motor_driver #(
    .PWM_BITS   (8),
    .RAMP_DIV   (16),
    .RAMP_STEP  (8),
    .DEAD_CYCLES(32),
    .RUN_LIMIT  (1000)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .Up_Motor  (Up_Motor),
    .Down_Motor(Down_Motor),
    .Clear     (Clear),
    .PWM_Up    (PWM_Up),
    .PWM_Down  (PWM_Down),
    .Duty      (Duty),
    .Busy      (Busy),
    .Fault     (Fault)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (PWM_Up) up_hi++;
    if (PWM_Down) dn_hi++;
    if (PWM_Up && PWM_Down) overlap++;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic wait_idle(input string tag, input int unsigned budget);
    for (int unsigned i = 0; i < budget; i++) begin
      if (!Busy) break;
      step(1);
    end
    check(tag, Busy, 0);
  endtask

  initial begin
    int exp_duty;
    int base_up, base_dn;
    int gap;
    int seen;

    RST = 1'b1; Up_Motor = 1'b0; Down_Motor = 1'b0; Clear = 1'b0;
    step(3);
    check("rst_duty", Duty, 0);
    check("rst_busy", Busy, 0);
    check("rst_fault", Fault, 0);
    check("rst_pwm_up", PWM_Up, 0);
    check("rst_pwm_dn", PWM_Down, 0);
    RST = 1'b0;
    step(2);
    check("idle_no_cmd", Busy, 0);

    // Up ramp: 0,8,...,248,255 every 16 cycles.
    base_dn = dn_hi;
    Up_Motor = 1'b1;
    step(1);
    check("ru_enter_busy", Busy, 1);
    check("ru_enter_duty", Duty, 0);
    step(15);
    check("ru_before_tick", Duty, 0);
    step(1);
    check("ru_tick1", Duty, 8);
    for (int k = 2; k <= 32; k++) begin
      step(16);
      exp_duty = (8 * k > 255) ? 255 : 8 * k;
      check($sformatf("ru_tick%0d", k), Duty, exp_duty);
    end
    check("ru_dn_quiet", dn_hi - base_dn, 0);

    base_up = up_hi; base_dn = dn_hi;
    step(256);
    check("run_up_255of256", up_hi - base_up, 255);
    check("run_dn_quiet", dn_hi - base_dn, 0);

    // Stop from RUN: ramp down, 32 dead cycles, then IDLE.
    Up_Motor = 1'b0;
    step(1);
    check("stop_start_duty", Duty, 255);
    check("stop_start_busy", Busy, 1);
    for (int k = 1; k <= 32; k++) begin
      step(16);
      exp_duty = (255 - 8 * k < 0) ? 0 : 255 - 8 * k;
      check($sformatf("rd_tick%0d", k), Duty, exp_duty);
    end
    step(1);
    base_up = up_hi; base_dn = dn_hi;
    step(30);
    check("dead_busy", Busy, 1);
    step(1);
    check("dead_exit_idle", Busy, 0);
    step(1);
    check("dead_quiet", (up_hi - base_up) + (dn_hi - base_dn), 0);
    check("idle_stays", Busy, 0);

    // Reversal during up RUN.
    Up_Motor = 1'b1;
    step(513);
    check("rev_run_duty", Duty, 255);
    Up_Motor = 1'b0; Down_Motor = 1'b1;
    step(1);
    check("rev_start_duty", Duty, 255);
    step(512);
    check("rev_zero_duty", Duty, 0);
    gap = 0; seen = 0;
    for (int i = 0; i < 600; i++) begin
      step(1);
      if (PWM_Up) gap = 0;
      else if (PWM_Down) begin
        seen = 1;
        break;
      end else gap++;
    end
    check("rev_down_seen", seen, 1);
    check("rev_gap_ge_32", (gap >= 32) ? 1 : 0, 1);
    base_up = up_hi;
    step(256);
    check("rev_up_quiet", up_hi - base_up, 0);
    Down_Motor = 1'b0;
    wait_idle("rev_idle", 1200);

    // Conflict at Duty=64, then command return resumes the up ramp.
    Up_Motor = 1'b1;
    step(129);
    check("conf_pre_duty", Duty, 64);
    Down_Motor = 1'b1;
    step(1);
    check("conf_hold_duty", Duty, 64);
    check("conf_busy", Busy, 1);
    step(16);
    check("conf_down_tick", Duty, 56);
    Down_Motor = 1'b0;
    step(1);
    check("resume_hold", Duty, 56);
    step(16);
    check("resume_up_tick", Duty, 64);
    Up_Motor = 1'b0;
    wait_idle("conf_idle", 1000);

    // Asynchronous reset mid-RUN, asserted off the clock edge.
    Up_Motor = 1'b1;
    step(513);
    check("rst_run_duty", Duty, 255);
    #3;
    RST = 1'b1;
    #1;
    check("rst_async_pwm", PWM_Up, 0);
    check("rst_async_duty", Duty, 0);
    check("rst_async_busy", Busy, 0);
    step(2);
    RST = 1'b0;
    step(1);
    check("rst_restart_busy", Busy, 1);
    check("rst_restart_duty", Duty, 0);
    step(16);
    check("rst_restart_tick", Duty, 8);

    // Stall timeout.
    RST = 1'b1;
    step(1);
    RST = 1'b0;
    step(513);
    check("stall_run_duty", Duty, 255);
`ifdef STALL_TIMEOUT_EN
    step(999);
    check("stall_pre_fault", Fault, 0);
    check("stall_pre_duty", Duty, 255);
    step(1);
    check("stall_fault", Fault, 1);
    check("stall_duty0", Duty, 0);
    step(1);
    check("stall_pwm_up", PWM_Up, 0);
    check("stall_pwm_dn", PWM_Down, 0);
    check("stall_busy", Busy, 1);
    Clear = 1'b1;
    step(1);
    check("clear_fault", Fault, 0);
    check("clear_idle", Busy, 0);
    Clear = 1'b0; Up_Motor = 1'b0;
    step(2);
    check("clear_stay_idle", Busy, 0);
`else
    step(1200);
    check("nostall_fault", Fault, 0);
    check("nostall_duty", Duty, 255);
    Clear = 1'b1;
    step(1);
    check("nostall_clear_busy", Busy, 1);
    check("nostall_clear_duty", Duty, 255);
    check("nostall_clear_fault", Fault, 0);
    Clear = 1'b0; Up_Motor = 1'b0;
    wait_idle("nostall_idle", 1200);
`endif

    check("no_overlap", overlap, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/garage_motor_driver.md
GARAGE_MOTOR_DRIVER -- requirements
Module: garage_motor_driver

Interface
REQ-001 Parameter PWM_BITS, default 8: width of duty register and PWM counter.
REQ-002 Parameter RAMP_DIV, default 16: clock cycles per ramp tick.
REQ-003 Parameter RAMP_STEP, default 8: duty change per ramp tick.
REQ-004 Parameter DEAD_CYCLES, default 32: cycles with both bridge outputs off between runs.
REQ-005 Parameter RUN_LIMIT, default 100000: maximum cycles allowed in RUN before a stall fault.
REQ-006 Port CLK, input, 1 bit: the single clock; all logic is rising-edge.
REQ-007 Port RST, input, 1 bit: asynchronous, active-high reset.
REQ-008 Port Up_Motor, input, 1 bit: open-door command from the garage door controller.
REQ-009 Port Down_Motor, input, 1 bit: close-door command from the garage door controller.
REQ-010 Port Clear, input, 1 bit: synchronous fault clear.
REQ-011 Port PWM_Up, output, 1 bit: registered high-side gate drive, up direction.
REQ-012 Port PWM_Down, output, 1 bit: registered high-side gate drive, down direction.
REQ-013 Port Duty, output, PWM_BITS: current duty value.
REQ-014 Port Busy, output, 1 bit: high in any state except IDLE.
REQ-015 Port Fault, output, 1 bit: latched stall fault.

Function
REQ-016 The block SHALL decode the commands as:
- cmd_up = Up_Motor & ~Down_Motor.
- cmd_dn = Down_Motor & ~Up_Motor.
- Both inputs high, or both low, means stop.
REQ-017 The block SHALL implement states IDLE, RAMP_UP, RUN, RAMP_DOWN, DEAD and FAULT, with a registered direction bit dir.
REQ-018 In IDLE, the first cycle with cmd_up or cmd_dn SHALL load dir, clear the prescaler and enter RAMP_UP.
REQ-019 In RAMP_UP and RAMP_DOWN, a ramp tick SHALL occur when the prescaler reaches RAMP_DIV-1; the prescaler then wraps to 0.
REQ-020 On each RAMP_UP tick, Duty SHALL increase by RAMP_STEP, saturating at 2^PWM_BITS-1; reaching saturation SHALL enter RUN.
REQ-021 On each RAMP_DOWN tick, Duty SHALL decrease by RAMP_STEP, saturating at 0; reaching 0 SHALL enter DEAD with the dead counter cleared.
REQ-022 In RAMP_UP or RUN, loss of the command for dir (stop or reverse) SHALL enter RAMP_DOWN on the next cycle, starting from the present Duty.
REQ-023 In RAMP_DOWN, return of the command for the current dir SHALL re-enter RAMP_UP without passing through DEAD.
REQ-024 DEAD SHALL last exactly DEAD_CYCLES cycles. On exit:
- A valid command SHALL load dir and enter RAMP_UP.
- Otherwise the block SHALL enter IDLE.
REQ-025 A free-running PWM_BITS counter SHALL wrap at 2^PWM_BITS-1 and is never cleared except by reset.
REQ-026 The output drive SHALL follow these rules, registered with one cycle of latency:
- PWM_Up = (dir==up) & (pwm_cnt < Duty) & state in {RAMP_UP, RUN, RAMP_DOWN}.
- PWM_Down is the same with dir==down.
REQ-027 PWM_Up and PWM_Down SHALL never be high in the same cycle.
REQ-028 Any direction reversal SHALL include at least DEAD_CYCLES cycles with both outputs low.
REQ-029 In FAULT, the block SHALL force Duty=0 and both outputs low.
REQ-030 Clear while in FAULT SHALL enter IDLE on the next cycle; Clear in any other state SHALL be ignored.

Reset
REQ-031 RST high SHALL immediately force the following, regardless of CLK:
- state IDLE, dir up.
- Duty 0, pwm_cnt 0, prescaler 0, dead and run counters 0.
- PWM_Up 0, PWM_Down 0, Busy 0, Fault 0.
REQ-032 Reset asserted mid-ramp or mid-run SHALL drop both outputs without a ramp-down; after release, operation SHALL resume from IDLE.

Configuration
REQ-033 With macro STALL_TIMEOUT_EN defined, the block SHALL include the stall timeout:
- A run counter counts cycles in RUN and clears on leaving RUN.
- When the count reaches RUN_LIMIT, the block SHALL enter FAULT and set Fault=1.
REQ-034 Without STALL_TIMEOUT_EN, the run counter and the FAULT entry path SHALL be absent, Fault SHALL be tied 0, and Clear SHALL be ignored.

Verification
REQ-035 Up ramp: Up_Motor=1 from IDLE, defaults -> Duty steps 0,8,...,248,255 every 16 cycles; RUN is reached after 32 ticks (512 cycles); PWM_Up is high for 255 of every 256 cycles in RUN; PWM_Down stays 0.
REQ-036 Stop: Up_Motor dropped in RUN -> Duty ramps to 0 in 32 ticks, then 32 DEAD cycles with both outputs 0, then IDLE and Busy=0.
REQ-037 Reversal: Down_Motor=1, Up_Motor=0 during an up RUN -> ramp-down to 0, then 32 cycles with both outputs low, then PWM_Down ramping; the bench checks every cycle that PWM_Up and PWM_Down are never both 1.
REQ-038 Conflict: Up_Motor=Down_Motor=1 in RAMP_UP at Duty=64 -> RAMP_DOWN begins on the next cycle from 64.
REQ-039 Stall (STALL_TIMEOUT_EN, RUN_LIMIT=1000): hold Up_Motor=1 -> Fault=1 and outputs 0 after 1000 RUN cycles; Clear=1 -> IDLE on the next cycle and Fault=0.
REQ-040 Reset: RST=1 asserted mid-RUN, off-edge -> PWM_Up=0 and Duty=0 immediately; after RST=0 with Up_Motor still 1, RAMP_UP restarts from 0.
